ni_inject_arbiter: RTL and testbench
====================================

Name:
ni_inject_arbiter

Overview:
- Round-robin packet arbiter that shares the single NoC-side injection port of the NI (i_flit/enable/ready) between NUM_REQ local flit sources.
- Grants a whole packet at a time (head, body..., tail; PKT_FLITS flits) and locks the grant until the tail flit transfers.
- Sits between local packet generators and the top NI/APB bridge. Its o_flit/o_enable drive the NI i_flit/enable; its ni_ready input is driven by the NI ready.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- FLIT_W, 16, flit width in bits.
- PKT_FLITS, ni_pkg::TOTAL_FLITS, flits per packet; must be >= 2.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req_flit  in  NUM_REQ x FLIT_W  flit offered by each requester.
- req_valid  in  NUM_REQ  requester r offers req_flit[r].
- req_ready  out  NUM_REQ  flit r accepted when req_valid[r] & req_ready[r].
- o_flit  out  FLIT_W  flit to the NI (registered).
- o_enable  out  1  o_flit valid this cycle (registered).
- ni_ready  in  1  NI can accept a flit one cycle later.
- gnt_id  out  $clog2(NUM_REQ)  current or last granted requester.
- busy  out  1  packet in progress (state SEND).

Behaviour:
- Reset values (async on resetn=0): state IDLE, o_flit 0, o_enable 0, req_ready 0, gnt_id 0, busy 0, flit_cnt 0, rr_ptr 0.
- FSM, IDLE:
  - If any req_valid is high, select the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register the selection into gnt_id, clear flit_cnt, and go to SEND.
  - req_ready stays all 0 in IDLE.
- FSM, SEND:
  - req_ready[gnt_id] = ni_ready (combinational). All other req_ready bits are 0.
  - On a handshake: o_flit <= req_flit[gnt_id], o_enable <= 1 on the next edge, flit_cnt++.
  - Without a handshake: o_enable <= 0 and o_flit holds its last value.
  - When the handshake hits flit_cnt == PKT_FLITS-1 (the tail): go to IDLE, rr_ptr <= (gnt_id+1) mod NUM_REQ, flit_cnt <= 0.
- Latency: req_valid high in IDLE at edge N gives grant at N+1. The first handshake is possible at N+1, and o_enable is high at N+2.
  - Best-case packet: 1 + PKT_FLITS cycles.
  - At least one IDLE cycle is inserted between packets.
- Grant lock:
  - If the granted requester drops req_valid mid-packet, bubbles are inserted (o_enable=0) and the grant is held.
  - Other requesters are never served mid-packet.
- ni_ready low: no handshake and o_enable=0 next cycle. The NI is guaranteed to accept any flit presented with o_enable that followed ni_ready=1.
- Simultaneous requests in IDLE: only the round-robin winner is granted. The others wait.
  - Fairness bound: a continuously requesting source waits at most NUM_REQ-1 packets.
- rr_ptr wraps from NUM_REQ-1 to 0. gnt_id holds its last value in IDLE.
- Flit content is not inspected; head/body/tail position is derived purely from flit_cnt.
- Reset mid-packet: immediate return to reset values. The partial packet is discarded, and requesters must restart from the head flit.

Optional Feature:
- Macro NI_INJECT_ARB_STATS_EN.
- Defined:
  - Adds output pkt_cnt (NUM_REQ x 16): per-requester count of completed packets, incremented on the tail handshake, wrapping at 16'hFFFF→0, reset to 0.
  - Adds output stall_cnt (16 bits): counts cycles in SEND where the granted req_valid=1 and ni_ready=0. It saturates at 16'hFFFF.
- Undefined: neither port nor their counters exist. All other behaviour is identical.

Decomposition:
- ni_pkg gains:
  - ARB_NUM_REQ constant.
  - arb_state_e enum (ARB_IDLE, ARB_SEND).
  - The flit_t typedef (logic [15:0]).
- PKT_FLITS defaults to the existing ni_pkg TOTAL_FLITS.
- One sub-module, rr_picker: combinational first-set search of a req vector starting at a pointer. It outputs found and idx, and is reusable by later APB-side arbiters.

Test Plan:
- Single requester: r2 sends a PKT_FLITS=4 packet 16'hA001, 16'h0011, 16'h0022, 16'hF0FF with ni_ready=1 → o_enable high for 4 consecutive cycles starting 2 cycles after req_valid, flits in order, gnt_id=2, then busy=0 and rr_ptr=3.
- Contention: r0 and r3 both valid in IDLE with rr_ptr=0 → r0 packet completes fully, 1 IDLE cycle, then r3 packet. With r0 re-requesting immediately, the next grant after r3 is r0, with no r3 starvation.
- Backpressure: ni_ready toggles 1,0,0,1 mid-body → o_enable=0 on the cycles after each ni_ready=0, no flit lost or duplicated, r1 req_ready mirrors ni_ready.
- Grant lock: the granted r1 drops req_valid for 3 cycles after the head while r2 is valid → o_enable=0 for those cycles, r2 req_ready stays 0, r1 finishes before r2 is granted.
- Reset mid-packet: resetn=0 after 2 of 4 flits → all outputs 0 asynchronously. After release, r1 resends the full packet and exactly 4 flits appear.
- With NI_INJECT_ARB_STATS_EN: 3 packets from r0 and 2 from r1 → pkt_cnt[0]=3, pkt_cnt[1]=2. 5 stalled cycles gives stall_cnt=5.

Source files
------------

// File: rtl/ni_pkg.sv
// ni_pkg: shared types and constants for the network-interface blocks.
//
// Contents:
//   TOTAL_FLITS  - flits per packet (head, bodies, tail)
//   ARB_NUM_REQ  - default number of local sources sharing the NI injection port
//   flit_t       - one flit on the NoC side
//   arb_state_e  - injection arbiter FSM states
//   rr_next      - round-robin pointer advance with wrap
package ni_pkg;

  localparam int TOTAL_FLITS = 4;
  localparam int ARB_NUM_REQ = 4;

  typedef logic [15:0] flit_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arb_state_e;

  // Next round-robin start position after serving 'idx' out of 'n' sources.
  function automatic int rr_next(input int idx, input int n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin first-set search.
//
// Scans req_i starting at position ptr_i, then ptr_i+1, ... wrapping modulo N,
// and reports the first set bit. Kept generic so APB-side arbiters can reuse it.
//
// Ports:
//   req_i   in  N       request vector
//   ptr_i   in  IW      search start position (must be < N)
//   found_o out 1       at least one request bit is set
//   idx_o   out IW      index of the winning request (0 when none)
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // One extra bit so ptr_i + offset cannot overflow before the wrap subtract.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    found_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cand = sum[IW-1:0];
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/ni_inject_arbiter.sv
// ni_inject_arbiter: packet-granular round-robin arbiter in front of the NI
// injection port.
//
// NUM_REQ local flit sources compete for the single NI i_flit/enable/ready
// port. A winner owns the port for a whole packet (PKT_FLITS flits) and the
// grant is only released by the tail handshake. Packet position is tracked
// purely by a flit counter; flit contents are never inspected.
//
// Ports:
//   clk        in   1                  system clock
//   resetn     in   1                  asynchronous active-low reset
//   req_flit   in   NUM_REQ x FLIT_W   flit offered by each source
//   req_valid  in   NUM_REQ            source r offers req_flit[r]
//   req_ready  out  NUM_REQ            transfer when req_valid[r] & req_ready[r]
//   o_flit     out  FLIT_W             registered flit to the NI
//   o_enable   out  1                  registered o_flit valid
//   ni_ready   in   1                  NI accepts a flit one cycle later
//   gnt_id     out  clog2(NUM_REQ)     current or last granted source
//   busy       out  1                  packet in progress
//
// Optional build macro NI_INJECT_ARB_STATS_EN adds:
//   pkt_cnt    out  NUM_REQ x 16       completed packets per source (wraps)
//   stall_cnt  out  16                 SEND cycles stalled by the NI (saturates)
module ni_inject_arbiter
  import ni_pkg::*;
#(
  parameter int NUM_REQ   = ARB_NUM_REQ,
  parameter int FLIT_W    = 16,
  parameter int PKT_FLITS = TOTAL_FLITS
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NUM_REQ-1:0][FLIT_W-1:0]   req_flit,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [FLIT_W-1:0]                o_flit,
  output logic                             o_enable,
  input  logic                             ni_ready,
  output logic [$clog2(NUM_REQ)-1:0]       gnt_id,
  output logic                             busy
`ifdef NI_INJECT_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]         pkt_cnt,
  output logic [15:0]                      stall_cnt
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(PKT_FLITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(PKT_FLITS - 1);

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    gnt_q, gnt_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic              en_q, en_d;

  logic              pick_found;
  logic [IDW-1:0]    pick_idx;
  logic              hs;
  logic              tail_hs;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_picker (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      flit_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      flit_q  <= flit_d;
      en_q    <= en_d;
    end
  end

  // o_enable is a one-cycle pulse per accepted flit; o_flit keeps the last
  // accepted flit so bubbles do not disturb the data lines. req_ready only
  // depends on ni_ready so a dropped req_valid cannot steal the port.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    flit_d    = flit_q;
    en_d      = 1'b0;
    req_ready = '0;
    hs        = 1'b0;
    tail_hs   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          cnt_d   = '0;
          state_d = ARB_SEND;
        end
      end

      ARB_SEND: begin
        req_ready[gnt_q] = ni_ready;
        hs = req_valid[gnt_q] & ni_ready;
        if (hs) begin
          flit_d = req_flit[gnt_q];
          en_d   = 1'b1;
          if (cnt_q == LAST_CNT) begin
            tail_hs = 1'b1;
            cnt_d   = '0;
            state_d = ARB_IDLE;
            rr_d    = IDW'(rr_next(int'(gnt_q), NUM_REQ));
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign o_flit   = flit_q;
  assign o_enable = en_q;
  assign gnt_id   = gnt_q;
  assign busy     = (state_q == ARB_SEND);

`ifdef NI_INJECT_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] pkt_cnt_q;
  logic [15:0]              stall_cnt_q;
  logic                     stall_cyc;

  // A stall is the NI refusing a flit the granted source is actually offering;
  // source-side bubbles are not counted.
  assign stall_cyc = (state_q == ARB_SEND) & req_valid[gnt_q] & ~ni_ready;

  // Packet counters wrap naturally; the stall counter saturates.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (tail_hs) begin
        pkt_cnt_q[gnt_q] <= pkt_cnt_q[gnt_q] + 16'd1;
      end
      if (stall_cyc && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ni_inject_arbiter.sv
// tb_ni_inject_arbiter: directed self-checking bench for ni_inject_arbiter.
// Inputs are driven just after the falling edge; outputs are sampled there too,
// well away from the rising (active) edge. Each source replays a fixed
// 4-flit packet and advances only when it sees its own handshake.
module tb_ni_inject_arbiter;
  import ni_pkg::*;

  localparam int NR = 4;
  localparam int FW = 16;
  localparam int PF = 4;

  logic                    clk    = 1'b0;
  logic                    resetn = 1'b1;
  logic [NR-1:0][FW-1:0]   req_flit;
  logic [NR-1:0]           req_valid;
  logic [NR-1:0]           req_ready;
  logic [FW-1:0]           o_flit;
  logic                    o_enable;
  logic                    ni_ready;
  logic [1:0]              gnt_id;
  logic                    busy;
`ifdef NI_INJECT_ARB_STATS_EN
  logic [NR-1:0][15:0]     pkt_cnt;
  logic [15:0]             stall_cnt;
`endif

  int pos [NR];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ni_inject_arbiter #(
    .NUM_REQ   (NR),
    .FLIT_W    (FW),
    .PKT_FLITS (PF)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_flit  (req_flit),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .o_flit    (o_flit),
    .o_enable  (o_enable),
    .ni_ready  (ni_ready),
    .gnt_id    (gnt_id),
    .busy      (busy)
`ifdef NI_INJECT_ARB_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Packet contents per source: r2 uses the fixed test packet, others 0xN00k.
  function automatic logic [15:0] flit_of(input int r, input int k);
    logic [15:0] v;
    if (r == 2) begin
      case (k)
        0:       v = 16'hA001;
        1:       v = 16'h0011;
        2:       v = 16'h0022;
        default: v = 16'hF0FF;
      endcase
    end else begin
      v = {4'(r + 1), 8'h00, 4'(k)};
    end
    return v;
  endfunction

  always_comb begin
    for (int r = 0; r < NR; r++) begin
      req_flit[r] = flit_of(r, pos[r]);
    end
  end

  // Advance one clock: latch which sources handshake at the coming edge,
  // wait for the next falling edge, then move those sources to their next flit.
  task automatic step();
    logic [NR-1:0] hs;
    #1;
    hs = req_valid & req_ready;
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      if (hs[r]) pos[r] = (pos[r] + 1) % PF;
    end
    #1;
  endtask

  task automatic test_reset();
    req_valid = '0;
    ni_ready  = 1'b0;
    for (int r = 0; r < NR; r++) pos[r] = 0;
    #1 resetn = 1'b0;
    #11;
    n_cmp++; if (o_enable !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_en got %0b want 0", o_enable); end
    n_cmp++; if (o_flit !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset_flit got %h want 0000", o_flit); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (gnt_id !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_gnt got %0d want 0", gnt_id); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset_ready got %b want 0000", req_ready); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_single();
    logic [15:0] exp [4];
    exp = '{16'hA001, 16'h0011, 16'h0022, 16'hF0FF};
    ni_ready  = 1'b1;
    req_valid = 4'b0100;
    step();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL single_busy got %0b want 1", busy); end
    n_cmp++; if (gnt_id !== 2'd2) begin n_bad++; $display("[TB] FAIL single_gnt got %0d want 2", gnt_id); end
    n_cmp++; if (o_enable !== 1'b0) begin n_bad++; $display("[TB] FAIL single_en_grant got %0b want 0", o_enable); end
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("[TB] FAIL single_ready got %b want 0100", req_ready); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (o_enable !== 1'b1) begin n_bad++; $display("[TB] FAIL single_en k=%0d got %0b want 1", k, o_enable); end
      n_cmp++; if (o_flit !== exp[k]) begin n_bad++; $display("[TB] FAIL single_flit k=%0d got %h want %h", k, o_flit, exp[k]); end
      n_cmp++; if (busy !== (k < 3)) begin n_bad++; $display("[TB] FAIL single_busy k=%0d got %0b want %0b", k, busy, (k < 3)); end
    end
    req_valid = '0;
    step();
    n_cmp++; if (o_enable !== 1'b0) begin n_bad++; $display("[TB] FAIL single_en_after got %0b want 0", o_enable); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL single_busy_after got %0b want 0", busy); end
    n_cmp++; if (gnt_id !== 2'd2) begin n_bad++; $display("[TB] FAIL single_gnt_hold got %0d want 2", gnt_id); end
  endtask

  // rr_ptr is 3 after the r2 packet, so r3 goes first, then r0, r3, r0.
  task automatic test_contention();
    int order [4];
    order = '{3, 0, 3, 0};
    ni_ready  = 1'b1;
    req_valid = 4'b1001;
    for (int p = 0; p < 4; p++) begin
      step();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL cont_busy p=%0d got %0b want 1", p, busy); end
      n_cmp++; if (gnt_id !== 2'(order[p])) begin n_bad++; $display("[TB] FAIL cont_gnt p=%0d got %0d want %0d", p, gnt_id, order[p]); end
      n_cmp++; if (o_enable !== 1'b0) begin n_bad++; $display("[TB] FAIL cont_gap p=%0d got %0b want 0", p, o_enable); end
      n_cmp++; if (req_ready !== (4'b0001 << order[p])) begin n_bad++; $display("[TB] FAIL cont_ready p=%0d got %b want %b", p, req_ready, (4'b0001 << order[p])); end
      for (int k = 0; k < 4; k++) begin
        step();
        n_cmp++; if (o_enable !== 1'b1) begin n_bad++; $display("[TB] FAIL cont_en p=%0d k=%0d got %0b want 1", p, k, o_enable); end
        n_cmp++; if (o_flit !== flit_of(order[p], k)) begin n_bad++; $display("[TB] FAIL cont_flit p=%0d k=%0d got %h want %h", p, k, o_flit, flit_of(order[p], k)); end
        n_cmp++; if (busy !== (k < 3)) begin n_bad++; $display("[TB] FAIL cont_busy_k p=%0d k=%0d got %0b want %0b", p, k, busy, (k < 3)); end
      end
    end
    req_valid = '0;
    step();
    n_cmp++; if (o_enable !== 1'b0) begin n_bad++; $display("[TB] FAIL cont_en_end got %0b want 0", o_enable); end
  endtask

  // rr_ptr is 1 here: r1 alone, NI ready pattern 1,1,0,0,1,1.
  task automatic test_backpressure();
    logic        rdy_tab [6];
    logic        en_tab  [6];
    logic [15:0] fl_tab  [6];
    rdy_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    en_tab  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    fl_tab  = '{16'h2000, 16'h2001, 16'h2001, 16'h2001, 16'h2002, 16'h2003};
    ni_ready  = 1'b1;
    req_valid = 4'b0010;
    step();
    n_cmp++; if (gnt_id !== 2'd1) begin n_bad++; $display("[TB] FAIL bp_gnt got %0d want 1", gnt_id); end
    for (int i = 0; i < 6; i++) begin
      ni_ready = rdy_tab[i];
      #1;
      n_cmp++; if (req_ready !== (rdy_tab[i] ? 4'b0010 : 4'b0000)) begin n_bad++; $display("[TB] FAIL bp_ready i=%0d got %b want %b", i, req_ready, (rdy_tab[i] ? 4'b0010 : 4'b0000)); end
      step();
      n_cmp++; if (o_enable !== en_tab[i]) begin n_bad++; $display("[TB] FAIL bp_en i=%0d got %0b want %0b", i, o_enable, en_tab[i]); end
      n_cmp++; if (o_flit !== fl_tab[i]) begin n_bad++; $display("[TB] FAIL bp_flit i=%0d got %h want %h", i, o_flit, fl_tab[i]); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_busy_end got %0b want 0", busy); end
    ni_ready  = 1'b1;
    req_valid = '0;
    step();
  endtask

  // rr_ptr is 2 here; r1 is granted alone, then r2 joins while r1 idles.
  task automatic test_grant_lock();
    logic [3:0]  vld_tab [7];
    logic        en_tab  [7];
    logic [15:0] fl_tab  [7];
    vld_tab = '{4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0110, 4'b0110};
    en_tab  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    fl_tab  = '{16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2001, 16'h2002, 16'h2003};
    ni_ready  = 1'b1;
    req_valid = 4'b0010;
    step();
    n_cmp++; if (gnt_id !== 2'd1) begin n_bad++; $display("[TB] FAIL lock_gnt got %0d want 1", gnt_id); end
    for (int i = 0; i < 7; i++) begin
      req_valid = vld_tab[i];
      #1;
      n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("[TB] FAIL lock_ready i=%0d got %b want 0010", i, req_ready); end
      n_cmp++; if (gnt_id !== 2'd1) begin n_bad++; $display("[TB] FAIL lock_gnt_hold i=%0d got %0d want 1", i, gnt_id); end
      step();
      n_cmp++; if (o_enable !== en_tab[i]) begin n_bad++; $display("[TB] FAIL lock_en i=%0d got %0b want %0b", i, o_enable, en_tab[i]); end
      n_cmp++; if (o_flit !== fl_tab[i]) begin n_bad++; $display("[TB] FAIL lock_flit i=%0d got %h want %h", i, o_flit, fl_tab[i]); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL lock_busy_end got %0b want 0", busy); end
    req_valid = 4'b0100;
    step();
    n_cmp++; if (gnt_id !== 2'd2) begin n_bad++; $display("[TB] FAIL lock_next_gnt got %0d want 2", gnt_id); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (o_flit !== flit_of(2, k)) begin n_bad++; $display("[TB] FAIL lock_r2_flit k=%0d got %h want %h", k, o_flit, flit_of(2, k)); end
    end
    req_valid = '0;
    step();
  endtask

  // rr_ptr is 3 here; r1 is granted, reset lands after two flits.
  task automatic test_reset_mid();
    int nfl;
    ni_ready  = 1'b1;
    req_valid = 4'b0010;
    step();
    n_cmp++; if (gnt_id !== 2'd1) begin n_bad++; $display("[TB] FAIL rst_gnt got %0d want 1", gnt_id); end
    step();
    step();
    n_cmp++; if (o_flit !== 16'h2001) begin n_bad++; $display("[TB] FAIL rst_pre_flit got %h want 2001", o_flit); end
    resetn = 1'b0;
    #1;
    n_cmp++; if (o_enable !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_en got %0b want 0", o_enable); end
    n_cmp++; if (o_flit !== 16'h0000) begin n_bad++; $display("[TB] FAIL rst_mid_flit got %h want 0000", o_flit); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_busy got %0b want 0", busy); end
    n_cmp++; if (gnt_id !== 2'd0) begin n_bad++; $display("[TB] FAIL rst_mid_gnt got %0d want 0", gnt_id); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("[TB] FAIL rst_mid_ready got %b want 0000", req_ready); end
    @(negedge clk);
    for (int r = 0; r < NR; r++) pos[r] = 0;
    resetn = 1'b1;
    #1;
    step();
    n_cmp++; if (gnt_id !== 2'd1) begin n_bad++; $display("[TB] FAIL rst_regrant got %0d want 1", gnt_id); end
    nfl = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (o_enable === 1'b1) nfl++;
      n_cmp++; if (o_flit !== flit_of(1, k)) begin n_bad++; $display("[TB] FAIL rst_flit k=%0d got %h want %h", k, o_flit, flit_of(1, k)); end
    end
    req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (o_enable === 1'b1) nfl++;
    end
    n_cmp++; if (nfl !== 4) begin n_bad++; $display("[TB] FAIL rst_flit_count got %0d want 4", nfl); end
  endtask

`ifdef NI_INJECT_ARB_STATS_EN
  // After reset r0/r1 alternate: r0,r1,r0,r1,r0 = 20 flits, with 5 NI stalls.
  task automatic test_stats();
    int nfl;
    int stalls;
    int cyc;
    resetn    = 1'b0;
    req_valid = '0;
    ni_ready  = 1'b1;
    #1;
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL stats_rst_stall got %0d want 0", stall_cnt); end
    @(negedge clk);
    for (int r = 0; r < NR; r++) pos[r] = 0;
    resetn = 1'b1;
    #1;
    nfl = 0; stalls = 0; cyc = 0;
    while (nfl < 20 && cyc < 400) begin
      req_valid = 4'b0011;
      if (busy && stalls < 5 && (cyc % 3) == 0) begin
        ni_ready = 1'b0;
        stalls++;
      end else begin
        ni_ready = 1'b1;
      end
      step();
      if (o_enable === 1'b1) nfl++;
      cyc++;
    end
    n_cmp++; if (nfl !== 20) begin n_bad++; $display("[TB] FAIL stats_timeout flits got %0d want 20", nfl); end
    req_valid = '0;
    ni_ready  = 1'b1;
    step();
    n_cmp++; if (pkt_cnt[0] !== 16'd3) begin n_bad++; $display("[TB] FAIL stats_pkt0 got %0d want 3", pkt_cnt[0]); end
    n_cmp++; if (pkt_cnt[1] !== 16'd2) begin n_bad++; $display("[TB] FAIL stats_pkt1 got %0d want 2", pkt_cnt[1]); end
    n_cmp++; if (pkt_cnt[2] !== 16'd0) begin n_bad++; $display("[TB] FAIL stats_pkt2 got %0d want 0", pkt_cnt[2]); end
    n_cmp++; if (pkt_cnt[3] !== 16'd0) begin n_bad++; $display("[TB] FAIL stats_pkt3 got %0d want 0", pkt_cnt[3]); end
    n_cmp++; if (stall_cnt !== 16'd5) begin n_bad++; $display("[TB] FAIL stats_stall got %0d want 5", stall_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_grant_lock();
    test_reset_mid();
`ifdef NI_INJECT_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
